// File: rtl/mont_exp_sequencer_if.sv
// mont_exp_sequencer_if: bus between the exponent sequencer (master) and a Montgomery multiplier (slave)
//   mul_start   master->slave  one-cycle operation request
//   mul_a/mul_b master->slave  operands, held from mul_start until mul_done
//   mul_m       master->slave  odd modulus M
//   mul_result  slave->master  a*b*R^-1 mod M, valid while mul_done=1
//   mul_done    slave->master  completion pulse
interface mont_exp_sequencer_if #(parameter int DATA_W = 1024);
   logic              mul_start;
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic [DATA_W-1:0] mul_m;
   logic [DATA_W-1:0] mul_result;
   logic              mul_done;
   modport master (output mul_start, mul_a, mul_b, mul_m, input mul_result, mul_done);
   modport slave  (input mul_start, mul_a, mul_b, mul_m, output mul_result, mul_done);
endinterface

// File: rtl/mont_exp_sequencer.sv
// mont_exp_sequencer: left-to-right square-and-multiply sequencer driving one Montgomery multiplier
//   clk, resetn        clock and synchronous active-low reset
//   start_i            request, accepted only when idle
//   in_x_i, in_r_i     base x*R mod M and Montgomery one R mod M
//   in_m_i             odd modulus M
//   in_e_i, in_e_len_i exponent and its bit length (0 = empty, saturates at EXP_W)
//   mul                multiplier bus (master side)
//   result_o           final accumulator, held until the next accepted start
//   done_o, busy_o     completion pulse and busy flag
// Define MONT_EXP_CONV_EN to append a multiply-by-1 that leaves the result in plain form.
module mont_exp_sequencer #(
   parameter int DATA_W = 1024,
   parameter int EXP_W  = 1024,
   parameter int LEN_W  = 11
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start_i,
   input  logic [DATA_W-1:0]    in_x_i,
   input  logic [DATA_W-1:0]    in_r_i,
   input  logic [DATA_W-1:0]    in_m_i,
   input  logic [EXP_W-1:0]     in_e_i,
   input  logic [LEN_W-1:0]     in_e_len_i,
   mont_exp_sequencer_if.master mul,
   output logic [DATA_W-1:0]    result_o,
   output logic                 done_o,
   output logic                 busy_o
);
   typedef enum logic [2:0] {IDLE, SQ_GO, SQ_WAIT, MUL_GO, MUL_WAIT, CONV_GO, CONV_WAIT, FIN} state_t;
`ifdef MONT_EXP_CONV_EN
   localparam state_t END_S = CONV_GO;
`else
   localparam state_t END_S = FIN;
`endif
   state_t            state_q, state_d;
   logic [DATA_W-1:0] x_q, x_d, acc_q, acc_d, result_q, result_d, a_q, a_d, b_q, b_d, m_q, m_d;
   logic [EXP_W-1:0]  e_q, e_d;
   logic [LEN_W-1:0]  idx_q, idx_d, len_sat;
   logic              done_q, done_d, accept, last, e_bit;
   assign len_sat = (in_e_len_i > LEN_W'(EXP_W)) ? LEN_W'(EXP_W) : in_e_len_i;
   // the done cycle still counts as busy, so a start there is ignored
   assign accept  = (state_q == IDLE) && !done_q && start_i;
   assign last    = (idx_q == '0);
   assign e_bit   = |(e_q & (EXP_W'(1) << idx_q));
   always_ff @(posedge clk)
      if (!resetn) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = accept ? ((len_sat != '0) ? SQ_GO : END_S) : IDLE;
         SQ_GO:     state_d = SQ_WAIT;
         SQ_WAIT:   state_d = !mul.mul_done ? SQ_WAIT : e_bit ? MUL_GO : last ? END_S : SQ_GO;
         MUL_GO:    state_d = MUL_WAIT;
         MUL_WAIT:  state_d = !mul.mul_done ? MUL_WAIT : last ? END_S : SQ_GO;
`ifdef MONT_EXP_CONV_EN
         CONV_GO:   state_d = CONV_WAIT;
         CONV_WAIT: state_d = mul.mul_done ? FIN : CONV_WAIT;
`endif
         FIN:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end
   always_comb begin
      mul.mul_start = state_q inside {SQ_GO, MUL_GO, CONV_GO};
      busy_o        = (state_q != IDLE) || done_q;
   end
   // operands are loaded on entry to a *_GO state so they are stable for the whole multiplication
   always_comb begin
      x_d   = x_q;
      e_d   = e_q;
      m_d   = m_q;
      acc_d = acc_q;
      idx_d = idx_q;
      a_d   = a_q;
      b_d   = b_q;
      if (accept) begin
         x_d   = in_x_i;
         e_d   = in_e_i;
         m_d   = in_m_i;
         acc_d = in_r_i;
         idx_d = len_sat - LEN_W'(1);
      end
      if (state_q inside {SQ_WAIT, MUL_WAIT, CONV_WAIT} && mul.mul_done) acc_d = mul.mul_result;
      if (state_q inside {SQ_WAIT, MUL_WAIT} && state_d == SQ_GO) idx_d = idx_q - LEN_W'(1);
      if (state_d inside {SQ_GO, MUL_GO, CONV_GO}) begin
         a_d = acc_d;
         b_d = (state_d == SQ_GO) ? acc_d : (state_d == MUL_GO) ? x_q : DATA_W'(1);
      end
      result_d = (state_q == FIN) ? acc_q : result_q;
      done_d   = (state_q == FIN);
   end
   always_ff @(posedge clk)
      if (!resetn) begin
         x_q      <= '0;
         e_q      <= '0;
         m_q      <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         x_q      <= x_d;
         e_q      <= e_d;
         m_q      <= m_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   assign mul.mul_a = a_q;
   assign mul.mul_b = b_q;
   assign mul.mul_m = m_q;
   assign result_o  = result_q;
   assign done_o    = done_q;
endmodule

// File: tb/tb_mont_exp_sequencer.sv
// tb_mont_exp_sequencer: self-checking bench, DATA_W=8, M=13, R=256 (R mod M = 9, R^-1 mod M = 3)
module tb_mont_exp_sequencer;
   localparam int DW = 8, EW = 8, LW = 4;
`ifdef MONT_EXP_CONV_EN
   localparam bit CONV = 1'b1;
`else
   localparam bit CONV = 1'b0;
`endif
   logic          clk = 1'b0, resetn = 1'b0, start = 1'b0;
   logic [DW-1:0] in_x = '0, in_r = 8'd9, in_m = 8'd13, in_e = '0;
   logic [LW-1:0] in_len = '0;
   logic [DW-1:0] result;
   logic          done, busy;
   mont_exp_sequencer_if #(.DATA_W(DW)) mul ();
   mont_exp_sequencer #(.DATA_W(DW), .EXP_W(EW), .LEN_W(LW)) dut (
      .clk(clk), .resetn(resetn), .start_i(start), .in_x_i(in_x), .in_r_i(in_r), .in_m_i(in_m),
      .in_e_i(in_e), .in_e_len_i(in_len), .mul(mul), .result_o(result), .done_o(done), .busy_o(busy));
   always #5 clk = ~clk;
   int errors = 0, checks = 0, npulses = 0, lat_fix = 3, mcnt = 0;
   bit spur_en = 1'b0, mbusy = 1'b0;
   logic [DW-1:0] ca, cb;
   function automatic int mont(int a, int b);
      return (a * b * 3) % 13;
   endfunction
   // plain reference: x = x~ * R^-1, raise to the truncated exponent by repeated multiplication
   function automatic int ref_res(int xt, int e, int len);
      int x, l, ee, p;
      x = (xt * 3) % 13;
      l = (len > EW) ? EW : len;
      ee = e & ((1 << l) - 1);
      p = 1;
      for (int i = 0; i < ee; i++) p = (p * x) % 13;
      return CONV ? p : (p * 9) % 13;
   endfunction
   function automatic int ref_pul(int e, int len);
      int l;
      l = (len > EW) ? EW : len;
      return l + $countones(e & ((1 << l) - 1)) + (CONV ? 1 : 0);
   endfunction
   // multiplier model with configurable latency and optional spurious done pulses while idle
   always @(posedge clk) begin
      mul.mul_done <= 1'b0;
      if (!resetn) mbusy <= 1'b0;
      else if (mbusy) begin
         if (mul.mul_a !== ca || mul.mul_b !== cb || mul.mul_m !== 8'd13) begin
            errors++;
            $display("FAIL operand_hold: a=%0d b=%0d m=%0d want a=%0d b=%0d m=13", mul.mul_a, mul.mul_b, mul.mul_m, ca, cb);
         end
         if (mul.mul_start) begin
            errors++;
            $display("FAIL mul_start_reissue: got 1 want 0 while multiplier busy");
         end
         if (mcnt <= 1) begin
            mul.mul_done   <= 1'b1;
            mul.mul_result <= 8'(mont(int'(ca), int'(cb)));
            mbusy          <= 1'b0;
            checks++;
         end else mcnt <= mcnt - 1;
      end else if (mul.mul_start) begin
         ca      <= mul.mul_a;
         cb      <= mul.mul_b;
         mbusy   <= 1'b1;
         npulses <= npulses + 1;
         mcnt    <= (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 40));
      end else if (spur_en && !busy && !start && $urandom_range(0, 3) == 0) begin
         mul.mul_done   <= 1'b1;
         mul.mul_result <= 8'($urandom);
      end
   end
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask
   task automatic run_op(input logic [7:0] xt, input logic [7:0] e, input logic [3:0] len, input int poke,
                         output int res, output int pul, output int cyc);
      int p0;
      p0 = npulses;
      in_x = xt; in_r = 8'd9; in_m = 8'd13; in_e = e; in_len = len; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      chk("busy_after_start", busy, 1);
      while (!done && cyc < 4000) begin
         if (cyc == poke) begin
            start = 1'b1; in_x = 8'd7; in_e = 8'hFF; in_len = 4'd8;
         end else start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 1);
      res = int'(result);
      pul = npulses - p0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_clear", busy, 0);
      chk("result_hold", result, res);
   endtask
   typedef struct {
      logic [7:0] xt;
      logic [7:0] e;
      logic [3:0] len;
      int res_n, res_c, pul_n, pul_c;
   } vec_t;
   vec_t vecs[7];
   initial begin
      int res, pul, cyc, p0, n;
      vecs[0] = '{8'd5, 8'h00, 4'd0,  9, 1,  0,  1};
      vecs[1] = '{8'd5, 8'h05, 4'd3,  2, 6,  5,  6};
      vecs[2] = '{8'd5, 8'hFF, 4'd8,  7, 8, 16, 17};
      vecs[3] = '{8'd5, 8'hFF, 4'd12, 7, 8, 16, 17};
      vecs[4] = '{8'd5, 8'h80, 4'd8,  3, 9,  9, 10};
      vecs[5] = '{8'd5, 8'hF5, 4'd3,  2, 6,  5,  6};
      vecs[6] = '{8'd0, 8'h03, 4'd2,  0, 0,  4,  5};
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mul_start", mul.mul_start, 0);
      chk("rst_result", result, 0);
      chk("rst_mul_a", mul.mul_a, 0);
      chk("rst_mul_b", mul.mul_b, 0);
      chk("rst_mul_m", mul.mul_m, 0);
      resetn = 1'b1;
      @(negedge clk);
      foreach (vecs[i]) begin
         run_op(vecs[i].xt, vecs[i].e, vecs[i].len, 0, res, pul, cyc);
         chk($sformatf("vec%0d_result", i), res, CONV ? vecs[i].res_c : vecs[i].res_n);
         chk($sformatf("vec%0d_pulses", i), pul, CONV ? vecs[i].pul_c : vecs[i].pul_n);
`ifndef MONT_EXP_CONV_EN
         if (vecs[i].len == 4'd0) chk("len0_latency", cyc, 2);
`endif
      end
      lat_fix = 5;
      run_op(8'd5, 8'h05, 4'd3, 3, res, pul, cyc);
      chk("busy_start_result", res, CONV ? 6 : 2);
      chk("busy_start_pulses", pul, CONV ? 6 : 5);
      lat_fix = 8;
      in_x = 8'd5; in_e = 8'h05; in_len = 4'd3; start = 1'b1;
      p0 = npulses;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (npulses - p0 < 2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_mul_wait", npulses - p0, 2);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_mul_start", mul.mul_start, 0);
      chk("midrst_done", done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_mul_a", mul.mul_a, 0);
      resetn = 1'b1;
      @(negedge clk);
      run_op(8'd5, 8'h05, 4'd3, 0, res, pul, cyc);
      chk("after_rst_result", res, CONV ? 6 : 2);
      chk("after_rst_pulses", pul, CONV ? 6 : 5);
      lat_fix = 0;
      spur_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [7:0] xt, e;
         logic [3:0] len;
         xt  = 8'($urandom_range(0, 12));
         e   = 8'($urandom);
         len = 4'($urandom_range(0, 10));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run_op(xt, e, len, 0, res, pul, cyc);
         chk($sformatf("rand%0d_result x=%0d e=%0d len=%0d", k, xt, e, len), res, ref_res(int'(xt), int'(e), int'(len)));
         chk($sformatf("rand%0d_pulses", k), pul, ref_pul(int'(e), int'(len)));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
